// File: rtl/mem_stage_bw.sv
// mem_stage_bw: EX->ME pipeline registers with a byte-enabled data RAM and optional multi-cycle access latency.
// Defining MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of force-aligning them.
module mem_stage_bw #(
    parameter int DEPTH_LOG2 = 6,
    parameter int MEM_LAT    = 0,
    parameter int BIG_ENDIAN = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        StallOther,
    input  logic [31:0] Result_EX,
    input  logic [31:0] WrDat_EX,
    input  logic        RegWrite_EX,
    input  logic        MemToReg_EX,
    input  logic        MemWrite_EX,
    input  logic [1:0]  MemSize_EX,
    input  logic        MemSigned_EX,
    input  logic [4:0]  WriteReg_EX,
    output logic        MemBusy,
    output logic [31:0] RdDat_ME,
    output logic [31:0] Result_ME,
    output logic [4:0]  WriteReg_ME,
    output logic        RegWrite_ME,
    output logic        MemToReg_ME,
    output logic        Misalign_ME,
    output logic [31:0] ResultRdDat_ME
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [3:0] LAT = 4'(MEM_LAT);

    logic [31:0]           mem_q [2**DEPTH_LOG2];
    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [31:0]           RdDat_q, Result_q;
    logic [4:0]            WriteReg_q;
    logic                  RegWrite_q, MemToReg_q, Misalign_q;
    logic                  memop, misalign, done, stall_eff, wr_en, RegWrite_d;
    logic [DEPTH_LOG2+1:0] addr;
    logic [DEPTH_LOG2-1:0] widx;
    logic [1:0]            blane;
    logic                  hlane;
    logic [3:0]            be;
    logic [31:0]           wdata, rword, RdDat_d;
    logic [7:0]            bsel;
    logic [15:0]           hsel;

    assign memop = MemWrite_EX | MemToReg_EX;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = memop & (((MemSize_EX == 2'b01) & Result_EX[0]) |
                               (MemSize_EX[1] & (|Result_EX[1:0])));
    assign addr     = Result_EX[DEPTH_LOG2+1:0];
`else
    assign misalign = 1'b0;
    always_comb begin
        addr = Result_EX[DEPTH_LOG2+1:0];
        if (MemSize_EX == 2'b01)
            addr[0] = 1'b0;
        else if (MemSize_EX[1])
            addr[1:0] = 2'b00;
    end
`endif

    assign widx  = addr[DEPTH_LOG2+1:2];
    assign blane = (BIG_ENDIAN != 0) ? ~addr[1:0] : addr[1:0];
    assign hlane = (BIG_ENDIAN != 0) ? ~addr[1] : addr[1];

    always_comb begin
        case (MemSize_EX)
            2'b00: begin
                be    = 4'b0001 << blane;
                wdata = {4{WrDat_EX[7:0]}};
            end
            2'b01: begin
                be    = hlane ? 4'b1100 : 4'b0011;
                wdata = {2{WrDat_EX[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = WrDat_EX;
            end
        endcase
    end

    // Combinational read sees pre-write contents when a store targets the same word.
    assign rword = mem_q[widx];
    always_comb begin
        bsel = rword[{blane, 3'b000} +: 8];
        hsel = hlane ? rword[31:16] : rword[15:0];
        case (MemSize_EX)
            2'b00:   RdDat_d = {{24{MemSigned_EX & bsel[7]}}, bsel};
            2'b01:   RdDat_d = {{16{MemSigned_EX & hsel[15]}}, hsel};
            default: RdDat_d = rword;
        endcase
    end

    assign done       = (state_q == BUSY) && (cnt_q == 4'd1);
    assign MemBusy    = (MEM_LAT != 0) && memop && !done;
    assign stall_eff  = StallOther && (state_q != BUSY);
    assign wr_en      = MemWrite_EX & !flush & !misalign & ((MEM_LAT == 0) ? !StallOther : done);
    assign RegWrite_d = RegWrite_EX & !misalign;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++)
                if (be[i]) mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (MEM_LAT != 0 && memop && !StallOther) begin
                    state_q <= BUSY;
                    cnt_q   <= LAT;
                end
                BUSY: if (cnt_q == 4'd1) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            endcase
        end
    end

    // A busy access loads a bubble; data fields are held as don't-care.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RdDat_q <= '0; Result_q <= '0; WriteReg_q <= '0;
            RegWrite_q <= 1'b0; MemToReg_q <= 1'b0; Misalign_q <= 1'b0;
        end else if (flush) begin
            RdDat_q <= '0; Result_q <= '0; WriteReg_q <= '0;
            RegWrite_q <= 1'b0; MemToReg_q <= 1'b0; Misalign_q <= 1'b0;
        end else if (MemBusy) begin
            RegWrite_q <= 1'b0; MemToReg_q <= 1'b0; Misalign_q <= 1'b0;
        end else if (!stall_eff) begin
            RdDat_q    <= RdDat_d;
            Result_q   <= Result_EX;
            WriteReg_q <= WriteReg_EX;
            RegWrite_q <= RegWrite_d;
            MemToReg_q <= MemToReg_EX;
            Misalign_q <= misalign;
        end
    end

    assign RdDat_ME       = RdDat_q;
    assign Result_ME      = Result_q;
    assign WriteReg_ME    = WriteReg_q;
    assign RegWrite_ME    = RegWrite_q;
    assign MemToReg_ME    = MemToReg_q;
    assign Misalign_ME    = Misalign_q;
    assign ResultRdDat_ME = MemToReg_q ? RdDat_q : Result_q;
endmodule

// File: tb/tb_mem_stage_bw.sv
// Bench for mem_stage_bw: two instances (single-cycle little-endian, 3-cycle big-endian) against a byte-addressed memory model.
module tb_mem_stage_bw;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] res[2], wd[2];
    logic        rw[2], m2r[2], mw[2], sg[2], fl[2], st[2];
    logic [1:0]  sz[2];
    logic [4:0]  wr[2];
    logic        busy[2], rw_me[2], m2r_me[2], mis_me[2];
    logic [31:0] rd_me[2], res_me[2], rrd_me[2];
    logic [4:0]  wr_me[2];

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned nb[2] = '{256, 64};
    bit          big[2] = '{1'b0, 1'b1};
    int unsigned lat[2] = '{0, 3};
    logic [7:0]  mb[2][256];
    logic [31:0] tmp;

    mem_stage_bw #(.DEPTH_LOG2(6), .MEM_LAT(0), .BIG_ENDIAN(0)) u_a (
        .clk(clk), .reset(rst), .flush(fl[0]), .StallOther(st[0]),
        .Result_EX(res[0]), .WrDat_EX(wd[0]), .RegWrite_EX(rw[0]), .MemToReg_EX(m2r[0]),
        .MemWrite_EX(mw[0]), .MemSize_EX(sz[0]), .MemSigned_EX(sg[0]), .WriteReg_EX(wr[0]),
        .MemBusy(busy[0]), .RdDat_ME(rd_me[0]), .Result_ME(res_me[0]), .WriteReg_ME(wr_me[0]),
        .RegWrite_ME(rw_me[0]), .MemToReg_ME(m2r_me[0]), .Misalign_ME(mis_me[0]),
        .ResultRdDat_ME(rrd_me[0]));

    mem_stage_bw #(.DEPTH_LOG2(4), .MEM_LAT(3), .BIG_ENDIAN(1)) u_b (
        .clk(clk), .reset(rst), .flush(fl[1]), .StallOther(st[1]),
        .Result_EX(res[1]), .WrDat_EX(wd[1]), .RegWrite_EX(rw[1]), .MemToReg_EX(m2r[1]),
        .MemWrite_EX(mw[1]), .MemSize_EX(sz[1]), .MemSigned_EX(sg[1]), .WriteReg_EX(wr[1]),
        .MemBusy(busy[1]), .RdDat_ME(rd_me[1]), .Result_ME(res_me[1]), .WriteReg_ME(wr_me[1]),
        .RegWrite_ME(rw_me[1]), .MemToReg_ME(m2r_me[1]), .Misalign_ME(mis_me[1]),
        .ResultRdDat_ME(rrd_me[1]));

    function automatic int unsigned nbytes(logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit misaligned(logic [31:0] a, logic [1:0] s);
        return (a % nbytes(s)) != 0;
    endfunction

    // Memory is a flat byte array; endianness only decides which byte is most significant.
    function automatic logic [31:0] model_read(int d, logic [31:0] a0, logic [1:0] s, logic sgn);
        int unsigned n = nbytes(s);
        logic [31:0] a = a0;
        logic [31:0] v = '0;
        logic [31:0] byt;
`ifndef MEM_MISALIGN_TRAP_EN
        a = a0 - (a0 % n);
`endif
        for (int unsigned k = 0; k < n; k++) begin
            byt = {24'b0, mb[d][(a + k) % nb[d]]};
            v = v | (byt << (big[d] ? 8 * (n - 1 - k) : 8 * k));
        end
        if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic model_write(int d, logic [31:0] a0, logic [1:0] s, logic [31:0] data);
        int unsigned n = nbytes(s);
        logic [31:0] a = a0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (misaligned(a0, s)) return;
`else
        a = a0 - (a0 % n);
`endif
        for (int unsigned k = 0; k < n; k++)
            mb[d][(a + k) % nb[d]] = 8'(data >> (big[d] ? 8 * (n - 1 - k) : 8 * k));
    endtask

    task automatic drive_nop(int d);
        mw[d] = 1'b0; m2r[d] = 1'b0; rw[d] = 1'b0; st[d] = 1'b0; fl[d] = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the op reaches ME.
    task automatic run_op(input int d, input logic [31:0] a, input logic [1:0] s,
                          input logic ld, input logic stq, input logic sgn,
                          input logic [31:0] data, input logic regw, input logic [4:0] dst,
                          input bit busy_stall, output logic [31:0] rd_exp);
        bit memop = ld | stq;
        bit tm = 1'b0;
        int unsigned cyc;
        logic [31:0] exp_rrd;
`ifdef MEM_MISALIGN_TRAP_EN
        tm = memop && misaligned(a, s);
`endif
        cyc = memop ? lat[d] + 1 : 1;
        rd_exp = model_read(d, a, s, sgn);
        if (stq) model_write(d, a, s, data);
        res[d] = a; wd[d] = data; sz[d] = s; m2r[d] = ld; mw[d] = stq;
        sg[d] = sgn; rw[d] = regw; wr[d] = dst; st[d] = 1'b0; fl[d] = 1'b0;
        for (int unsigned c = 0; c < cyc; c++) begin
            #1;
            n_checks++;
            if (busy[d] !== (c + 1 < cyc)) begin
                n_fail++;
                $display("FAIL busy dut%0d cycle %0d: got %b expected %b", d, c, busy[d], (c + 1 < cyc));
            end
            @(negedge clk);
            if (busy_stall && lat[d] > 0) st[d] = 1'($urandom_range(0, 1));
            if (c + 1 < cyc) begin
                n_checks++;
                if ({rw_me[d], m2r_me[d], mis_me[d]} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL bubble dut%0d cycle %0d: got rw/m2r/mis=%b%b%b expected 000",
                             d, c, rw_me[d], m2r_me[d], mis_me[d]);
                end
            end
        end
        st[d] = 1'b0;
        n_checks++;
        if ({res_me[d], wr_me[d], m2r_me[d], rw_me[d], mis_me[d]} !== {a, dst, ld, regw & !tm, tm}) begin
            n_fail++;
            $display("FAIL me_ctrl dut%0d: got res=%h wr=%0d m2r=%b rw=%b mis=%b expected res=%h wr=%0d m2r=%b rw=%b mis=%b",
                     d, res_me[d], wr_me[d], m2r_me[d], rw_me[d], mis_me[d], a, dst, ld, regw & !tm, tm);
        end
        if (!(ld && tm)) begin
            exp_rrd = ld ? rd_exp : a;
            n_checks++;
            if (rrd_me[d] !== exp_rrd) begin
                n_fail++;
                $display("FAIL resultrddat dut%0d addr %h: got %h expected %h", d, a, rrd_me[d], exp_rrd);
            end
            if (ld) begin
                n_checks++;
                if (rd_me[d] !== rd_exp) begin
                    n_fail++;
                    $display("FAIL rddat dut%0d addr %h size %0d: got %h expected %h", d, a, s, rd_me[d], rd_exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            drive_nop(d);
            res[d] = '0; wd[d] = '0; sz[d] = 2'b10; sg[d] = 1'b0; wr[d] = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({busy[d], rd_me[d], res_me[d], wr_me[d], rw_me[d], m2r_me[d], mis_me[d], rrd_me[d]} !== '0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got busy=%b rd=%h res=%h wr=%0d rw=%b m2r=%b mis=%b expected all zero",
                         d, busy[d], rd_me[d], res_me[d], wr_me[d], rw_me[d], m2r_me[d], mis_me[d]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic init_ram();
        for (int unsigned i = 0; i < 64; i++) run_op(0, 4 * i, 2'b10, 0, 1, 0, $urandom, 0, 5'd0, 0, tmp);
        drive_nop(0);
        for (int unsigned i = 0; i < 16; i++) run_op(1, 4 * i, 2'b10, 0, 1, 0, $urandom, 0, 5'd0, 0, tmp);
        drive_nop(1);
    endtask

    task automatic test_word_a();
        run_op(0, 32'h10, 2'b10, 0, 1, 0, 32'hDEADBEEF, 0, 5'd0, 0, tmp);
        run_op(0, 32'h10, 2'b10, 1, 0, 0, 32'h0, 1, 5'd3, 0, tmp);
        n_checks++;
        if (rd_me[0] !== 32'hDEADBEEF || rrd_me[0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_load: got rd=%h rrd=%h expected deadbeef", rd_me[0], rrd_me[0]);
        end
    endtask

    task automatic test_byte_a();
        run_op(0, 32'h10, 2'b10, 0, 1, 0, 32'h11223344, 0, 5'd0, 0, tmp);
        run_op(0, 32'h13, 2'b00, 0, 1, 0, 32'h777777A5, 0, 5'd0, 0, tmp);
        run_op(0, 32'h10, 2'b10, 1, 0, 0, 32'h0, 1, 5'd1, 0, tmp);
        n_checks++;
        if (rd_me[0] !== 32'hA5223344) begin
            n_fail++; $display("FAIL byte_merge: got %h expected a5223344", rd_me[0]);
        end
        run_op(0, 32'h13, 2'b00, 1, 0, 1, 32'h0, 1, 5'd2, 0, tmp);
        n_checks++;
        if (rd_me[0] !== 32'hFFFFFFA5) begin
            n_fail++; $display("FAIL lb_signed: got %h expected ffffffa5", rd_me[0]);
        end
        run_op(0, 32'h13, 2'b00, 1, 0, 0, 32'h0, 1, 5'd2, 0, tmp);
        n_checks++;
        if (rd_me[0] !== 32'h000000A5) begin
            n_fail++; $display("FAIL lb_unsigned: got %h expected 000000a5", rd_me[0]);
        end
    endtask

    task automatic test_alias_a();
        run_op(0, 32'h100, 2'b10, 0, 1, 0, 32'h12345678, 0, 5'd0, 0, tmp);
        run_op(0, 32'h0, 2'b10, 1, 0, 0, 32'h0, 1, 5'd6, 0, tmp);
        n_checks++;
        if (rd_me[0] !== 32'h12345678) begin
            n_fail++; $display("FAIL alias: got %h expected 12345678", rd_me[0]);
        end
    endtask

    task automatic test_stall_a();
        run_op(0, 32'h1234, 2'b10, 0, 0, 0, 32'h0, 1, 5'd7, 0, tmp);
        res[0] = 32'h40; wd[0] = 32'hCAFEF00D; sz[0] = 2'b10; mw[0] = 1'b1; m2r[0] = 1'b0;
        rw[0] = 1'b1; wr[0] = 5'd2; st[0] = 1'b1;
        repeat (2) begin
            #1;
            n_checks++;
            if (busy[0] !== 1'b0) begin
                n_fail++; $display("FAIL stall_busy: got %b expected 0", busy[0]);
            end
            @(negedge clk);
            n_checks++;
            if ({res_me[0], wr_me[0], rw_me[0], m2r_me[0]} !== {32'h1234, 5'd7, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold: got res=%h wr=%0d rw=%b expected res=00001234 wr=7 rw=1",
                         res_me[0], wr_me[0], rw_me[0]);
            end
        end
        run_op(0, 32'h40, 2'b10, 1, 0, 0, 32'h0, 1, 5'd2, 0, tmp);
    endtask

    task automatic test_misalign_a();
        run_op(0, 32'h20, 2'b10, 0, 1, 0, 32'h55667788, 0, 5'd0, 0, tmp);
        run_op(0, 32'h21, 2'b01, 0, 1, 0, 32'h1234BEEF, 1, 5'd8, 0, tmp);
        n_checks++;
`ifdef MEM_MISALIGN_TRAP_EN
        if ({mis_me[0], rw_me[0]} !== 2'b10) begin
            n_fail++; $display("FAIL misalign_flag: got mis=%b rw=%b expected mis=1 rw=0", mis_me[0], rw_me[0]);
        end
`else
        if ({mis_me[0], rw_me[0]} !== 2'b01) begin
            n_fail++; $display("FAIL misalign_flag: got mis=%b rw=%b expected mis=0 rw=1", mis_me[0], rw_me[0]);
        end
`endif
        run_op(0, 32'h20, 2'b10, 1, 0, 0, 32'h0, 1, 5'd9, 0, tmp);
        n_checks++;
`ifdef MEM_MISALIGN_TRAP_EN
        if (rd_me[0] !== 32'h55667788) begin
            n_fail++; $display("FAIL misalign_data: got %h expected 55667788", rd_me[0]);
        end
`else
        if (rd_me[0] !== 32'h5566BEEF) begin
            n_fail++; $display("FAIL misalign_data: got %h expected 5566beef", rd_me[0]);
        end
`endif
    endtask

    task automatic test_latency_b();
        run_op(1, 32'h0000_0AAA, 2'b10, 0, 0, 0, 32'h0, 1, 5'd4, 0, tmp);
        run_op(1, 32'h4, 2'b10, 1, 0, 0, 32'h0, 1, 5'd5, 0, tmp);
        drive_nop(1);
        #1;
        n_checks++;
        if (busy[1] !== 1'b0) begin
            n_fail++; $display("FAIL latency_idle_busy: got %b expected 0", busy[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_stall_b();
        run_op(1, 32'h55, 2'b10, 0, 0, 0, 32'h0, 1, 5'd4, 0, tmp);
        res[1] = 32'h8; sz[1] = 2'b10; m2r[1] = 1'b1; mw[1] = 1'b0; rw[1] = 1'b1;
        wr[1] = 5'd5; sg[1] = 1'b0; st[1] = 1'b1;
        repeat (2) begin
            #1;
            n_checks++;
            if (busy[1] !== 1'b1) begin
                n_fail++; $display("FAIL stall_b_busy: got %b expected 1", busy[1]);
            end
            @(negedge clk);
            n_checks++;
            if ({res_me[1], rw_me[1]} !== {32'h55, 1'b0}) begin
                n_fail++; $display("FAIL stall_b_bubble: got res=%h rw=%b expected res=00000055 rw=0", res_me[1], rw_me[1]);
            end
        end
        run_op(1, 32'h8, 2'b10, 1, 0, 0, 32'h0, 1, 5'd5, 0, tmp);
    endtask

    task automatic test_flush_b();
        run_op(1, 32'h77, 2'b10, 0, 0, 0, 32'h0, 1, 5'd12, 0, tmp);
        res[1] = 32'h8; wd[1] = 32'h0BADF00D; sz[1] = 2'b10; mw[1] = 1'b1; m2r[1] = 1'b0;
        rw[1] = 1'b0; wr[1] = 5'd3;
        #1;
        @(negedge clk);
        fl[1] = 1'b1;
        #1;
        n_checks++;
        if (busy[1] !== 1'b1) begin
            n_fail++; $display("FAIL flush_busy: got %b expected 1", busy[1]);
        end
        @(negedge clk);
        fl[1] = 1'b0;
        n_checks++;
        if ({rd_me[1], res_me[1], wr_me[1], rw_me[1], m2r_me[1], mis_me[1], rrd_me[1]} !== '0) begin
            n_fail++;
            $display("FAIL flush_clear: got rd=%h res=%h wr=%0d rw=%b expected all zero",
                     rd_me[1], res_me[1], wr_me[1], rw_me[1]);
        end
        run_op(1, 32'h8, 2'b10, 1, 0, 0, 32'h0, 1, 5'd3, 0, tmp);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int unsigned kind;
        for (int unsigned i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            run_op(0, a, 2'($urandom_range(0, 3)), kind == 1, kind == 2, 1'($urandom_range(0, 1)),
                   $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 0, tmp);
        end
        drive_nop(0);
        for (int unsigned i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            run_op(1, a, 2'($urandom_range(0, 3)), kind == 1, kind == 2, 1'($urandom_range(0, 1)),
                   $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1, tmp);
        end
        drive_nop(1);
    endtask

    task automatic test_async_reset();
        run_op(0, 32'h00C0FFEE, 2'b10, 0, 0, 0, 32'h0, 1, 5'd10, 0, tmp);
        drive_nop(0);
        run_op(1, 32'h00ABCDEF, 2'b10, 0, 0, 0, 32'h0, 1, 5'd9, 0, tmp);
        res[1] = 32'hC; sz[1] = 2'b10; m2r[1] = 1'b1; mw[1] = 1'b0; rw[1] = 1'b1; wr[1] = 5'd11;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({rd_me[d], res_me[d], wr_me[d], rw_me[d], m2r_me[d], mis_me[d], rrd_me[d]} !== '0) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got rd=%h res=%h wr=%0d rw=%b expected all zero",
                         d, rd_me[d], res_me[d], wr_me[d], rw_me[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 32'hC, 2'b10, 1, 0, 0, 32'h0, 1, 5'd11, 0, tmp);
        drive_nop(1);
    endtask

    initial begin
        test_reset();
        init_ram();
        test_word_a();
        test_byte_a();
        test_alias_a();
        test_stall_a();
        test_misalign_a();
        drive_nop(0);
        test_latency_b();
        test_stall_b();
        test_flush_b();
        drive_nop(1);
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
